regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the 8-entry register file among four write-back requesters (e.g. ALU, load unit, multiplier, CSR path). It grants at most one valid/ready handshake per cycle and registers the winner's address and data. It then drives the registered `wr_address`/`wr_write`/`wr_data` into the register file's write-enable decoder and data input one cycle later. A `hold` input lets the pipeline controller freeze write-back.

## Interface
- `DATA_WIDTH`, default 16: width of one register's write data.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  4: bit i = requester i presents a write.
- `req_addr`  in  12: requester i target register at bits [3i+2:3i].
- `req_data`  in  4*DATA_WIDTH: requester i data at bits [DATA_WIDTH*i +: DATA_WIDTH].
- `req_ready`  out  4: one-hot or zero; bit i = requester i's write accepted this cycle.
- `hold`  in  1: 1 = accept no requests this cycle.
- `wr_write`  out  1: registered write strobe to the register-file decoder.
- `wr_address`  out  3: registered target register index.
- `wr_data`  out  DATA_WIDTH: registered write data.
- `wr_grant`  out  2: index of the requester whose write is on `wr_*`.
- `write_count`  out  16: number of committed writes, wraps modulo 2^16.

## Operation
- State: 2-bit round-robin pointer `ptr`, output registers `wr_*`, and `write_count`.
- Arbitration is combinational from `req_valid`, `hold` and `ptr`. `req_ready` never depends on itself.
  - Scan order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first requester with valid=1 wins.
  - If `hold`=1 or no valid is set, `req_ready`=0000.
- A handshake occurs for requester i when `req_valid[i]` & `req_ready[i]`. At the next edge:
  - `wr_write`←1, `wr_address`←addr_i, `wr_data`←data_i, `wr_grant`←i.
  - `ptr`←(i+1) mod 4.
  - `write_count`←`write_count`+1, with 16-bit wrap.
- Without a handshake (idle or `hold`=1):
  - `wr_write`←0.
  - `wr_address`, `wr_data`, `wr_grant`, `ptr` and `write_count` keep their values.
- A requester keeps valid, addr and data stable until it sees ready. Deasserting valid before ready withdraws the request with no side effects.
- Two requesters targeting the same register are serialized in grant order. The later grant overwrites the earlier one. No merging is performed.
- Fairness: with `hold`=0, a continuously valid requester is granted within 4 cycles of asserting valid.

## Timing
- Reset (asynchronous, `rst_n`=0), independent of the clock:
  - `ptr`=0, `wr_write`=0, `wr_address`=0, `wr_data`=0, `wr_grant`=0, `write_count`=0.
  - `req_ready`=0000 while `rst_n`=0.
- Latency: the handshake at edge N appears on `wr_*` during cycle N+1, and the register file writes at edge N+1.
- Throughput: one write per cycle.
- `hold` takes effect in the same cycle it is asserted: `req_ready`=0000 immediately, and `wr_write`=0 in the following cycle.
- Reset mid-operation: an accepted write not yet committed by the register file is dropped, because `wr_write` is forced to 0. Requesters must re-present the write after reset.
- `write_count` 0xFFFF + 1 → 0x0000, with no flag.

## Test plan
- Reset: assert `rst_n`=0 mid-traffic → all outputs 0 asynchronously, `req_ready`=0000. Release it, then requester 2 writes → grant goes to 2 (first valid requester scanning from `ptr`=0).
- Single request: `req_valid`=0100, addr2=5, data2=0x1234 → `req_ready`=0100 in the same cycle. Next cycle: `wr_write`=1, `wr_address`=5, `wr_data`=0x1234, `wr_grant`=2, `write_count`=1.
- Full contention: all four valid for 8 cycles from reset → grants 0,1,2,3,0,1,2,3 and `write_count`=8.
- Pointer wrap: set `ptr`=3 (after granting 2), then requesters 1 and 3 valid → 3 granted first, then 1, with `ptr`=2 afterwards.
- Hold: all valid, `hold`=1 for 3 cycles → `req_ready`=0000, `wr_write`=0, `ptr` unchanged. When `hold` drops, grants resume from the same `ptr`.
- Counter wrap: preload `write_count` to 0xFFFE by 65534 writes (or by forcing it), then 2 writes → 0x0000.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among four write-back
// requesters; the winner's address/data are registered onto wr_* one cycle later.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req_valid,
  input  logic [11:0]             req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  output logic [3:0]              req_ready,
  input  logic                    hold,
  output logic                    wr_write,
  output logic [2:0]              wr_address,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [1:0]              wr_grant,
  output logic [15:0]             write_count
);

  logic [1:0]            ptr_q, ptr_d;
  logic                  wr_write_q, wr_write_d;
  logic [2:0]            wr_address_q, wr_address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            wr_grant_q, wr_grant_d;
  logic [15:0]           write_count_q, write_count_d;

  logic [3:0]            grant_oh;
  logic [1:0]            grant_idx;
  logic                  grant_any;
  logic [1:0]            scan_idx;
  logic [2:0]            addr_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // Ready is gated by rst_n so nothing can look accepted while reset is asserted.
  always_comb begin
    grant_oh  = 4'b0000;
    grant_idx = ptr_q;
    grant_any = 1'b0;
    scan_idx  = ptr_q;
    if (!hold && rst_n) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = ptr_q + 2'(k);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any          = 1'b1;
          grant_idx          = scan_idx;
          grant_oh[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_oh;

  always_comb begin
    addr_sel = 3'd0;
    data_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_idx == 2'(i)) begin
        addr_sel = req_addr[3*i +: 3];
        data_sel = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    wr_write_d    = grant_any;
    wr_address_d  = wr_address_q;
    wr_data_d     = wr_data_q;
    wr_grant_d    = wr_grant_q;
    write_count_d = write_count_q;
    if (grant_any) begin
      ptr_d         = grant_idx + 2'd1;
      wr_address_d  = addr_sel;
      wr_data_d     = data_sel;
      wr_grant_d    = grant_idx;
      write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= 2'd0;
      wr_write_q    <= 1'b0;
      wr_address_q  <= 3'd0;
      wr_data_q     <= '0;
      wr_grant_q    <= 2'd0;
      write_count_q <= 16'd0;
    end else begin
      ptr_q         <= ptr_d;
      wr_write_q    <= wr_write_d;
      wr_address_q  <= wr_address_d;
      wr_data_q     <= wr_data_d;
      wr_grant_q    <= wr_grant_d;
      write_count_q <= write_count_d;
    end
  end

  assign wr_write    = wr_write_q;
  assign wr_address  = wr_address_q;
  assign wr_data     = wr_data_q;
  assign wr_grant    = wr_grant_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: hand-derived vector table plus a
// reference model whose accepted writes go through a scoreboard queue.
module tb_regfile_write_arbiter;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [11:0]   req_addr;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_ready;
  logic          hold;
  logic          wr_write;
  logic [2:0]    wr_address;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_grant;
  logic [15:0]   write_count;

  regfile_write_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .wr_write(wr_write),
    .wr_address(wr_address), .wr_data(wr_data), .wr_grant(wr_grant),
    .write_count(write_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] data;
    logic [1:0]    grant;
  } wr_exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic        hold;
    logic [11:0] addr;
    logic [63:0] data;
    logic [3:0]  exp_ready;
    logic [15:0] exp_count;
  } vec_t;

  wr_exp_t     sb_q[$];
  vec_t        vecs[10];
  logic [1:0]  ref_ptr;
  logic [15:0] ref_count;
  logic [3:0]  last_ready;
  int          assertions;
  int          failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_ready(input logic [3:0] v, input logic h,
                                             input logic [1:0] p);
    logic [3:0] r;
    logic [1:0] idx;
    logic       found;
    r     = 4'b0000;
    found = 1'b0;
    if (!h) begin
      for (int k = 0; k < 4; k++) begin
        idx = p + 2'(k);
        if (!found && v[idx]) begin
          found  = 1'b1;
          r[idx] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input logic exp_write);
    wr_exp_t e;
    check("wr_write", 64'(wr_write), 64'(exp_write));
    if (exp_write) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("wr_address", 64'(wr_address), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("wr_grant", 64'(wr_grant), 64'(e.grant));
      end
    end
    check("write_count", 64'(write_count), 64'(ref_count));
  endtask

  // Called at posedge+1; samples ready mid-cycle, then checks wr_* after the edge.
  task automatic applyStimulus(input logic [3:0] v, input logic h,
                               input logic [11:0] a, input logic [63:0] d);
    logic [3:0] exp_r;
    logic       hs;
    wr_exp_t    e;
    req_valid = v;
    hold      = h;
    req_addr  = a;
    req_data  = d;
    #4;
    exp_r      = model_ready(v, h, ref_ptr);
    last_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_r));
    hs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_r[i]) begin
        hs      = 1'b1;
        e.addr  = a[3*i +: 3];
        e.data  = d[DW*i +: DW];
        e.grant = 2'(i);
        sb_q.push_back(e);
        ref_ptr   = 2'(i + 1);
        ref_count = ref_count + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(hs);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_write"}, 64'(wr_write), 64'(0));
    check({tag, "_address"}, 64'(wr_address), 64'(0));
    check({tag, "_data"}, 64'(wr_data), 64'(0));
    check({tag, "_grant"}, 64'(wr_grant), 64'(0));
    check({tag, "_count"}, 64'(write_count), 64'(0));
  endtask

  // Asserts reset mid-cycle with traffic present; leaves the bench at posedge+1.
  task automatic reset_mid;
    req_valid = 4'b1111;
    hold      = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    ref_ptr   = 2'd0;
    ref_count = 16'd0;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] DATA_ALL = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
  localparam logic [11:0] ADDR_ALL = {3'd7, 3'd6, 3'd5, 3'd4};

  initial begin
    assertions = 0;
    failures   = 0;
    ref_ptr    = 2'd0;
    ref_count  = 16'd0;
    hold       = 1'b0;
    req_addr   = ADDR_ALL;
    req_data   = DATA_ALL;
    req_valid  = 4'b1111;
    rst_n      = 1'b0;

    vecs[0] = '{4'b0100, 1'b0, {3'd0, 3'd5, 3'd0, 3'd0}, {16'h0, 16'h1234, 16'h0, 16'h0}, 4'b0100, 16'd1};
    vecs[1] = '{4'b1010, 1'b0, {3'd3, 3'd0, 3'd1, 3'd0}, {16'h3333, 16'h0, 16'h1111, 16'h0}, 4'b1000, 16'd2};
    vecs[2] = '{4'b0010, 1'b0, {3'd0, 3'd0, 3'd1, 3'd0}, {16'h0, 16'h0, 16'h1111, 16'h0}, 4'b0010, 16'd3};
    vecs[3] = '{4'b1111, 1'b1, ADDR_ALL, DATA_ALL, 4'b0000, 16'd3};
    vecs[4] = '{4'b1111, 1'b1, ADDR_ALL, DATA_ALL, 4'b0000, 16'd3};
    vecs[5] = '{4'b1111, 1'b0, ADDR_ALL, DATA_ALL, 4'b0100, 16'd4};
    vecs[6] = '{4'b0000, 1'b0, ADDR_ALL, DATA_ALL, 4'b0000, 16'd4};
    vecs[7] = '{4'b0011, 1'b0, ADDR_ALL, DATA_ALL, 4'b0001, 16'd5};
    vecs[8] = '{4'b0001, 1'b0, {3'd4, 3'd0, 3'd0, 3'd4}, {16'hBBBB, 16'h0, 16'h0, 16'hAAAA}, 4'b0001, 16'd6};
    vecs[9] = '{4'b1001, 1'b0, {3'd4, 3'd0, 3'd0, 3'd4}, {16'hBBBB, 16'h0, 16'h0, 16'hAAAA}, 4'b1000, 16'd7};

    #2;
    check_all_zero("reset");
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 10; n++) begin
      applyStimulus(vecs[n].valid, vecs[n].hold, vecs[n].addr, vecs[n].data);
      check($sformatf("vec%0d_ready", n), 64'(last_ready), 64'(vecs[n].exp_ready));
      check($sformatf("vec%0d_count", n), 64'(write_count), 64'(vecs[n].exp_count));
    end
    check("same_reg_last_data", 64'(wr_data), 64'(16'hBBBB));

    reset_mid();
    check("post_reset_write", 64'(wr_write), 64'(0));
    applyStimulus(4'b0100, 1'b0, ADDR_ALL, DATA_ALL);
    check("post_reset_grant", 64'(wr_grant), 64'(2));

    reset_mid();
    for (int n = 0; n < 8; n++) begin
      applyStimulus(4'b1111, 1'b0, ADDR_ALL, DATA_ALL);
      check($sformatf("contention_grant%0d", n), 64'(wr_grant), 64'(n % 4));
    end
    check("contention_count", 64'(write_count), 64'(8));

    applyStimulus(4'b1111, 1'b0, ADDR_ALL, DATA_ALL);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(4'b1111, 1'b1, ADDR_ALL, DATA_ALL);
    end
    applyStimulus(4'b1111, 1'b0, ADDR_ALL, DATA_ALL);
    check("hold_resume_grant", 64'(wr_grant), 64'(1));

    reset_mid();
    req_valid = 4'b0001;
    hold      = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    ref_count = 16'hFFFE;
    ref_ptr   = 2'd1;
    check("preload_count", 64'(write_count), 64'(16'hFFFE));
    applyStimulus(4'b0001, 1'b0, ADDR_ALL, DATA_ALL);
    applyStimulus(4'b0001, 1'b0, ADDR_ALL, DATA_ALL);
    check("count_wrap", 64'(write_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
